// File: rtl/wb_pkg.sv
// Shared types for the writeback commit queue: lane payload, beat type and exception codes.
package wb_pkg;

    localparam int unsigned WB_XLEN  = 32;
    localparam int unsigned WB_NLANE = 2;

    localparam logic [7:0] ECODE_INT = 8'h00;
    localparam logic [7:0] ECODE_PIL = 8'h01;
    localparam logic [7:0] ECODE_ADE = 8'h08;
    localparam logic [7:0] ECODE_ALE = 8'h09;
    localparam logic [7:0] ECODE_SYS = 8'h0b;
    localparam logic [7:0] ECODE_BRK = 8'h0c;
    localparam logic [7:0] ECODE_INE = 8'h0d;

    typedef struct packed {
        logic               valid;
        logic [WB_XLEN-1:0] pc;
        logic [WB_XLEN-1:0] result;
        logic               gr_we;
        logic [4:0]         dest;
        logic               ex;
        logic [7:0]         ecode;
        logic               esubcode;
        logic [WB_XLEN-1:0] vaddr;
    } lane_t;

    typedef lane_t [WB_NLANE-1:0] beat_t;

endpackage

// File: rtl/wb_beat_fifo.sv
// Generic in-order FIFO with async reset, sync clear, occupancy count and combinational head.
module wb_beat_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    always_comb begin
        count   = wptr_q - rptr_q;
        // Pointers carry one extra wrap bit so full and empty are distinguishable.
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && (count != '0);
        head    = mem_q[rptr_q[AW-1:0]];
        wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/wb_commit_queue.sv
// Multi-lane writeback stage: buffers beats in order and commits one beat per cycle with
// precise exceptions, same-destination write merging, hold and flush.
module wb_commit_queue
    import wb_pkg::*;
#(
    parameter int unsigned NLANE = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = WB_XLEN,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NLANE-1:0]      in_lane_valid,
    input  logic [NLANE*XLEN-1:0] in_pc,
    input  logic [NLANE*XLEN-1:0] in_result,
    input  logic [NLANE-1:0]      in_gr_we,
    input  logic [NLANE*5-1:0]    in_dest,
    input  logic [NLANE-1:0]      in_ex,
    input  logic [NLANE*8-1:0]    in_ecode,
    input  logic [NLANE-1:0]      in_esubcode,
    input  logic [NLANE*XLEN-1:0] in_vaddr,
    input  logic                  flush,
    input  logic                  hold,
    output logic [NLANE-1:0]      rf_we,
    output logic [NLANE*5-1:0]    rf_waddr,
    output logic [NLANE*XLEN-1:0] rf_wdata,
    output logic                  ex_valid,
    output logic [7:0]            ex_ecode,
    output logic                  ex_esubcode,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_vaddr,
    output logic [31:0]           commit_cnt,
    output logic [CW-1:0]         occupancy
);

    typedef lane_t [NLANE-1:0] lane_vec_t;

    lane_vec_t        in_beat, head;
    logic [CW-1:0]    count;
    logic             full;
    logic             push, fire, clr;
    logic             killed, ex_hit;
    lane_t            ex_lane;
    logic [NLANE-1:0] commit_lane, wr_lane;
    logic [2:0]       ncommit;
    logic [31:0]      commit_cnt_q, commit_cnt_d;

    always_comb begin
        in_beat = '0;
        for (int i = 0; i < NLANE; i++) begin
            in_beat[i].valid    = in_lane_valid[i];
            in_beat[i].pc       = in_pc[i*XLEN +: XLEN];
            in_beat[i].result   = in_result[i*XLEN +: XLEN];
            in_beat[i].gr_we    = in_gr_we[i];
            in_beat[i].dest     = in_dest[i*5 +: 5];
            in_beat[i].ex       = in_ex[i];
            in_beat[i].ecode    = in_ecode[i*8 +: 8];
            in_beat[i].esubcode = in_esubcode[i];
            in_beat[i].vaddr    = in_vaddr[i*XLEN +: XLEN];
        end
    end

    // No pass-through: a full queue refuses even when the head commits this cycle.
    assign in_ready  = !full;
    assign push      = in_valid && in_ready && !flush;
    assign fire      = (count != '0) && !hold && !flush;
    assign clr       = flush || ex_valid;
    assign occupancy = count;

    wb_beat_fifo #(
        .WIDTH ($bits(lane_vec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .wdata (in_beat),
        .pop   (fire),
        .head  (head),
        .count (count),
        .full  (full)
    );

    always_comb begin
        killed      = 1'b0;
        ex_hit      = 1'b0;
        ex_lane     = '0;
        commit_lane = '0;
        wr_lane     = '0;
        ncommit     = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (head[i].valid && head[i].ex && !killed) begin
                ex_hit  = 1'b1;
                ex_lane = head[i];
            end
            // The excepting lane and everything above it are killed.
            killed         = killed || (head[i].valid && head[i].ex);
            commit_lane[i] = fire && head[i].valid && !killed;
            wr_lane[i]     = commit_lane[i] && head[i].gr_we && (head[i].dest != 5'd0);
            ncommit        = ncommit + 3'(commit_lane[i]);
        end
    end

    always_comb begin
        rf_we    = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        for (int i = 0; i < NLANE; i++) begin
            rf_we[i] = wr_lane[i];
            for (int j = i + 1; j < NLANE; j++) begin
                if (wr_lane[j] && (head[j].dest == head[i].dest)) begin
                    rf_we[i] = 1'b0;
                end
            end
            if (fire) begin
                rf_waddr[i*5 +: 5]       = head[i].dest;
                rf_wdata[i*XLEN +: XLEN] = head[i].result;
            end
        end
    end

    always_comb begin
        ex_valid    = fire && ex_hit;
        ex_ecode    = '0;
        ex_esubcode = 1'b0;
        ex_pc       = '0;
        ex_vaddr    = '0;
        if (ex_valid) begin
            ex_ecode    = ex_lane.ecode;
            ex_esubcode = ex_lane.esubcode;
            ex_pc       = ex_lane.pc;
            ex_vaddr    = ex_lane.vaddr;
        end
    end

    assign commit_cnt_d = commit_cnt_q + 32'(ncommit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_cnt_q <= '0;
        end else begin
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign commit_cnt = commit_cnt_q;

endmodule
